rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 8-input byte mux between 8 requesters.
//  It selects one requester per transfer, captures that requester's data into a

---
 rtl/rr_mux_arbiter.sv | 74 +++++++
 tb/tb_rr_mux_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter feeding a registered, backpressured 8-lane mux
module rr_mux_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  input  logic [W-1:0] In1,
  input  logic [W-1:0] In2,
  input  logic [W-1:0] In3,
  input  logic [W-1:0] In4,
  input  logic [W-1:0] In5,
  input  logic [W-1:0] In6,
  input  logic [W-1:0] In7,
  input  logic [W-1:0] In8,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] Out,
  output logic [2:0]   sel,
  output logic [7:0]   ack
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
  state_t state, state_n;
  logic [2:0] ptr, start, win;
  logic [7:0] cand;
  logic accept, any, load;
  logic [W-1:0] lane [8];
  assign lane = '{In1, In2, In3, In4, In5, In6, In7, In8};
  assign out_valid = state == BUSY;
  assign accept = out_valid & out_ready & ~rst;
  assign ack = accept ? 8'd1 << sel : 8'd0;
  // during an accept the next search starts just past the requester being acked
  assign start = out_valid ? sel + 3'd1 : ptr;
  assign cand = req & ~ack;
  always_comb begin
    win = 3'd0;
    any = 1'b0;
    for (int k = 7; k >= 0; k--)
      if (cand[start + 3'(k)]) begin
        win = start + 3'(k);
        any = 1'b1;
      end
  end
  always_comb begin
    state_n = IDLE;
    load = 1'b0;
    case (state)
      IDLE: begin
        state_n = any ? BUSY : IDLE;
        load = any;
      end
      BUSY: begin
        state_n = (!out_ready || any) ? BUSY : IDLE;
        load = out_ready & any;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 3'd0;
      Out <= '0;
      ptr <= 3'd0;
    end else begin
      state <= state_n;
      if (load) begin
        sel <= win;
        Out <= lane[win];
      end
      if (accept) ptr <= sel + 3'd1;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] lane [8];
  logic out_ready = 1'b0;
  logic out_valid;
  logic [7:0] Out;
  logic [2:0] sel;
  logic [7:0] ack;
  int checks = 0;
  int failures = 0;
  logic m_valid;
  int m_sel, m_ptr, nxt;
  logic [7:0] m_out, m_ack, c;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .In1(lane[0]), .In2(lane[1]), .In3(lane[2]), .In4(lane[3]),
    .In5(lane[4]), .In6(lane[5]), .In7(lane[6]), .In8(lane[7]),
    .out_ready(out_ready), .out_valid(out_valid), .Out(Out), .sel(sel), .ack(ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_grant(input string tag, input int s, input logic [7:0] d);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_sel"}, 32'(sel), 32'(s));
    check({tag, "_out"}, 32'(Out), 32'(d));
  endtask

  // first set bit of m, scanning p, p+1, ... modulo 8; -1 if none
  function automatic int find(input int p, input logic [7:0] m);
    for (int k = 0; k < 8; k++)
      if (m[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) lane[i] = 8'h00;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_out", 32'(Out), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_ack", 32'(ack), 0);
    // single request, immediate accept
    rst = 1'b0; req = 8'h01; lane[0] = 8'hA5; out_ready = 1'b1;
    tick();
    expect_grant("t1", 0, 8'hA5);
    check("t1_ack", 32'(ack), 32'h01);
    req = 8'h00;
    tick();
    check("t1_idle", 32'(out_valid), 0);
    // all requesting: one transfer per cycle in rotation
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 8; i++) lane[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_grant($sformatf("t2_%0d", k), k % 8, 8'h10 + 8'(k % 8));
    end
    req = 8'h00;
    tick();
    check("t2_idle", 32'(out_valid), 0);
    // stall holds captured data despite lane change
    req = 8'h04; lane[2] = 8'h33; out_ready = 1'b0;
    tick();
    expect_grant("t3_grant", 2, 8'h33);
    lane[2] = 8'hCC;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_grant("t3_stall", 2, 8'h33);
      check("t3_stall_ack", 32'(ack), 0);
    end
    out_ready = 1'b1; #1;
    check("t3_ack", 32'(ack), 32'h04);
    tick();
    check("t3_idle", 32'(out_valid), 0);
    req = 8'h00;
    // ptr=3: search wraps to requester 1
    req = 8'h06; lane[1] = 8'h61; lane[2] = 8'h62;
    tick();
    expect_grant("t5_first", 1, 8'h61);
    check("t5_ack1", 32'(ack), 32'h02);
    tick();
    req = 8'h04;
    expect_grant("t5_second", 2, 8'h62);
    check("t5_ack2", 32'(ack), 32'h04);
    tick();
    req = 8'h00;
    check("t5_idle", 32'(out_valid), 0);
    // grant to 7 wraps ptr to 0
    req = 8'h80; lane[7] = 8'h77; lane[0] = 8'h70;
    tick();
    expect_grant("t4_seven", 7, 8'h77);
    tick();
    req = 8'h81;
    check("t4_idle", 32'(out_valid), 0);
    tick();
    expect_grant("t4_zero", 0, 8'h70);
    tick();
    req = 8'h80;
    expect_grant("t4_then7", 7, 8'h77);
    tick();
    req = 8'h00;
    // reset while stalled drops the transfer
    req = 8'h02; out_ready = 1'b0;
    tick();
    expect_grant("t6_busy", 1, 8'h61);
    rst = 1'b1; out_ready = 1'b1; #1;
    check("t6_rst_ack", 32'(ack), 0);
    tick();
    check("t6_valid", 32'(out_valid), 0);
    check("t6_ack", 32'(ack), 0);
    rst = 1'b0; req = 8'h81;
    tick();
    expect_grant("t6_restart", 0, 8'h70);
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    // randomized traffic against the reference model
    rst = 1'b1;
    m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_out = 8'h00;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      #1;
      m_ack = (m_valid && out_ready && !rst) ? 8'd1 << m_sel : 8'd0;
      check("rnd_valid", 32'(out_valid), 32'(m_valid));
      check("rnd_sel", 32'(sel), 32'(m_sel));
      check("rnd_out", 32'(Out), 32'(m_out));
      check("rnd_ack", 32'(ack), 32'(m_ack));
      if (rst) begin
        m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_out = 8'h00;
      end else if (!m_valid) begin
        nxt = find(m_ptr, req);
        if (nxt >= 0) begin
          m_valid = 1'b1; m_sel = nxt; m_out = lane[nxt];
        end
      end else if (out_ready) begin
        m_ptr = (m_sel + 1) % 8;
        c = req & ~m_ack;
        nxt = find(m_ptr, c);
        if (nxt >= 0) begin
          m_sel = nxt; m_out = lane[nxt];
        end else m_valid = 1'b0;
      end
      tick();
      for (int i = 0; i < 8; i++) begin
        lane[i] = 8'($urandom);
        if (m_ack[i] || !req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (m_valid && m_sel == i && $urandom_range(0, 7) == 0) req[i] = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
